// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-side blocks.
//   - ps2_state_e : host transmitter FSM states
//   - CMD_* / RSP_* : common keyboard command and response bytes
//   - odd_parity() : PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // PS/2 uses odd parity: the 8 data bits plus this bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 2-flop synchronizer plus falling-edge detect for one PS/2 line.
// Ports:
//   clk     in  system clock
//   clrn    in  synchronous active-low reset; all flops reset to idle-high
//   line_in in  raw asynchronous line
//   line_s  out synchronized line level
//   fe      out one-cycle falling-edge strobe (previous 1, current 0)
module ps2_edge_sync (
  input  logic clk,
  input  logic clrn,
  input  logic line_in,
  output logic line_s,
  output logic fe
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = line_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign line_s = s2_q;
  assign fe     = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Ports:
//   clk, clrn              system clock, synchronous active-low reset
//   tx_valid/tx_ready      byte request handshake; tx_data is the command byte
//   tx_done                one-cycle pulse: byte acknowledged and bus idle
//   tx_err                 one-cycle pulse: NACK or timeout
//   ps2_clk_in/data_in     raw open-drain line levels (asynchronous)
//   ps2_clk_oe/data_oe     1 pulls the line low, 0 releases it
//
// Handshake: a byte is accepted on a clock edge where tx_valid and tx_ready
// are both high; tx_data is captured on that edge and tx_valid while busy is
// ignored. One exception: in the cycle tx_done pulses, tx_ready is already
// high but the request is held off until the following cycle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  ps2_state_e     state_q, state_d;
  logic [IW-1:0]  inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]     bit_idx_q, bit_idx_d;
  logic [8:0]     shift_q, shift_d;     // {parity, data}, shifted out LSB first
  logic           data_oe_q, data_oe_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           clk_s, clk_fe;
  logic           data_s, data_fe_unused;
  logic           accept;
  logic           timed_state;

  ps2_edge_sync u_clk_sync (
    .clk     (clk),
    .clrn    (clrn),
    .line_in (ps2_clk_in),
    .line_s  (clk_s),
    .fe      (clk_fe)
  );

  ps2_edge_sync u_data_sync (
    .clk     (clk),
    .clrn    (clrn),
    .line_in (ps2_data_in),
    .line_s  (data_s),
    .fe      (data_fe_unused)
  );

  assign accept      = tx_valid && (state_q == ST_IDLE) && !done_q;
  assign timed_state = (state_q == ST_SHIFT) || (state_q == ST_ACK) ||
                       (state_q == ST_WAIT_IDLE);

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (accept) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          inh_cnt_d = '0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        // Start bit goes out together with the last clock-low cycle (REQ).
        if (inh_cnt_q == IW'(INHIBIT_CYC - 1)) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      ST_REQ: begin
        to_cnt_d  = '0;
        bit_idx_d = 4'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_fe) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd9) begin
            // Edges 1..9: 8 data bits then parity.
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end else begin
            // Edge 10: release the line as the stop bit.
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fe) begin
          if (!data_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Timeout covers everything from clock release to bus idle; a completion
    // in the same cycle takes priority.
    if (timed_state) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if ((to_cnt_q == TW'(TIMEOUT_CYC - 1)) && !done_d) begin
        data_oe_d = 1'b0;
        err_d     = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_idx_q <= 4'd0;
      shift_q   <= 9'd0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural
// PS/2 device that clocks at a 50-cycle period.
module tb_ps2_host_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 25;

  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_NONE  = 2;
  localparam int M_ABORT = 3;

  typedef struct {
    logic [7:0] data;
    int         mode;
    bit         exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit hold_valid = 1'b0;
  logic pulse_prev = 1'b0;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYC (INHIBIT),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: every pulse is one cycle wide and coincides with tx_ready.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done || tx_err) begin
      checks++;
      if (!tx_ready || pulse_prev) begin
        errors++;
        $display("FAIL pulse_shape: ready=%0b prev_pulse=%0b required ready=1 prev=0",
                 tx_ready, pulse_prev);
      end
    end
    pulse_prev = tx_done | tx_err;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (hold_valid) tx_data = 8'($urandom);
  endtask

  // Reference frame: 8 data bits LSB first, odd parity, stop = 1.
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    int ones;
    logic [9:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      if (d[i]) ones++;
    end
    f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic run_frame(input logic [7:0] d, input int mode, input bit exp_done);
    logic [9:0] exp_bits;
    logic [7:0] rx;
    int n, first_d, m, d0, e0;
    bit seen_done, seen_err;
    exp_bits = frame_bits(d);
    rx = 8'h00;
    d0 = done_cnt;
    e0 = err_cnt;

    tx_data  = d;
    tx_valid = 1'b1;
    chk("ready_idle", 32'(tx_ready), 32'd1);
    tick();
    if (!hold_valid) tx_valid = 1'b0;
    chk("accept_ready", 32'(tx_ready), 32'd0);
    chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);

    n = 0;
    first_d = 0;
    while (ps2_clk_oe && n < 100) begin
      n++;
      if (ps2_data_oe && first_d == 0) first_d = n;
      tick();
    end
    chk("inhibit_len", 32'(n), 32'(INHIBIT + 1));
    chk("start_cycle", 32'(first_d), 32'(INHIBIT + 1));

    if (mode == M_NONE) begin
      m = 0;
      while (!tx_err && m < 5000) begin
        tick();
        m++;
      end
      chk("timeout_cycles", 32'(m), 32'(TIMEOUT));
      tick();
      chk("timeout_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      chk("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
      chk("timeout_done_cnt", 32'(done_cnt - d0), 32'd0);
      return;
    end

    repeat (10) tick();
    chk("start_bit_line", 32'(ps2_data_line), 32'd0);

    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick();
      // Device samples just before its rising edge.
      if (k <= 8) rx[k-1] = ps2_data_line;
      chk($sformatf("bit%0d_line", k), 32'(ps2_data_line), 32'(exp_bits[k-1]));
      dev_clk = 1'b1;
      if (mode == M_ABORT && k == 4) begin
        tick();
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        chk("abort_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        chk("abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        return;
      end
      repeat (HALF) tick();
    end
    chk("rx_byte", 32'(rx), 32'(d));

    // Acknowledge clock: device pulls data low before the edge for an ACK.
    seen_done = 1'b0;
    seen_err  = 1'b0;
    if (mode == M_ACK) dev_data = 1'b0;
    repeat (5) tick();
    dev_clk = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      tick();
      if (tx_done) seen_done = 1'b1;
      if (tx_err) seen_err = 1'b1;
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    m = 0;
    while (!seen_done && !seen_err && m < 300) begin
      tick();
      m++;
      if (tx_done) seen_done = 1'b1;
      if (tx_err) seen_err = 1'b1;
    end
    chk("outcome_done", 32'(seen_done), 32'(exp_done));
    chk("outcome_err", 32'(seen_err), 32'(!exp_done));
    tick();
    if (hold_valid) begin
      // tx_valid was still high during the done pulse; it must not be taken then.
      chk("done_gate_ready", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      hold_valid = 1'b0;
    end
    chk("done_cnt", 32'(done_cnt - d0), 32'(exp_done));
    chk("err_cnt", 32'(err_cnt - e0), 32'(!exp_done));
    chk("released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[6];

  initial begin
    logic [7:0] rd;
    int rm;

    tbl[0] = '{8'hED, M_ACK,  1'b1};
    tbl[1] = '{8'h01, M_ACK,  1'b1};
    tbl[2] = '{8'hFF, M_NACK, 1'b0};
    tbl[3] = '{8'hF4, M_ACK,  1'b1};
    tbl[4] = '{8'h00, M_ACK,  1'b1};
    tbl[5] = '{8'h80, M_NACK, 1'b0};

    clrn = 1'b0;
    repeat (4) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    chk("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("reset_pulses", {30'd0, tx_done, tx_err}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].data, tbl[i].mode, tbl[i].exp_done);
      repeat (5) @(negedge clk);
    end

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rm = int'($urandom_range(0, 1));
      run_frame(rd, rm, rm == M_ACK);
      repeat (5) @(negedge clk);
    end

    // Device never clocks.
    run_frame(8'hF4, M_NONE, 1'b0);
    repeat (5) @(negedge clk);

    // Reset mid-frame, then a fresh command completes.
    run_frame(8'hED, M_ABORT, 1'b0);
    repeat (5) @(negedge clk);
    run_frame(8'hF4, M_ACK, 1'b1);
    repeat (5) @(negedge clk);

    // tx_valid held high with changing tx_data across a whole frame.
    hold_valid = 1'b1;
    run_frame(8'hED, M_ACK, 1'b1);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example 0xFF reset, 0xED set-LEDs and 0xF4 enable. It is the opposite direction of the keyboard receive path: it drives the shared ps2_clk/ps2_data lines through open-drain enables and runs the full request-to-send, bit-shift and acknowledge sequence. It sits beside the keyboard driver at top level and takes bytes from a simple valid/ready port.

## Interface
- INHIBIT_CYC, 12000: clk cycles that ps2_clk is held low before the request (120 µs at 100 MHz).
- TIMEOUT_CYC, 2000000: clk cycles allowed from clock release to the end of the acknowledge (20 ms).
- clk  in  1  system clock; the only clock.
- clrn  in  1  reset, synchronous, active-low.
- tx_valid  in  1  request to send tx_data; accepted only when tx_ready=1.
- tx_data  in  8  command byte.
- tx_ready  out  1  high in IDLE only.
- tx_done  out  1  one-cycle pulse: byte acknowledged and bus idle.
- tx_err  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
- ps2_data_in  in  1  raw PS/2 data line, asynchronous.
- ps2_clk_oe  out  1  1 pulls ps2_clk low; 0 releases it.
- ps2_data_oe  out  1  1 pulls ps2_data low; 0 releases it.

## Operation
- Both line inputs pass through a 2-flop synchronizer. A falling edge ("fe") is synchronized previous value 1 and current value 0.
- Frame bits are the 8 data bits LSB first, then the odd parity bit, then stop = 1 (line released). Parity bit = ~^tx_data.
- Handshake: when tx_valid & tx_ready, the block latches tx_data into a shift register and leaves IDLE. tx_valid while busy is ignored.
- States:
  - IDLE: both oe = 0, tx_ready = 1.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYC cycles.
  - REQ: clk_oe = 1 and data_oe = 1 (start bit) for 1 cycle.
  - SHIFT: clk_oe = 0, so the device clocks. On each fe, the data line is updated:
    - fe #1–8: data_oe = ~bit[i].
    - fe #9: data_oe = ~parity.
    - fe #10: data_oe = 0 (stop).
    - At fe #10 the block moves to ACK.
  - ACK: on the next fe, the block samples ps2_data_in. If 0, go to WAIT_IDLE; if 1, it is a NACK: pulse tx_err and go to IDLE.
  - WAIT_IDLE: when synchronized clk and data are both high, pulse tx_done and go to IDLE.
- Timeout counter: cleared on entry to SHIFT and incremented in SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYC, both oe are released, tx_err pulses, and the state returns to IDLE.
- A timeout and a completion in the same cycle resolve as completion; tx_done wins.
- Counter widths are $clog2 of each parameter, with 4-bit bit index. No wrap occurs, because each counter is cleared on state entry.

## Timing
- Reset (clrn=0 sampled on clk): state IDLE; ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, tx_done = 0, tx_err = 0; counters and synchronizers cleared to idle-high. Reset mid-frame releases both lines at the next clk edge.
- Acceptance cycle N: tx_ready = 0 and ps2_clk_oe = 1 from N+1.
- ps2_clk_oe stays high for exactly INHIBIT_CYC + 1 cycles, and ps2_data_oe rises in the last of those cycles.
- The data line updates 3 clk cycles after the raw falling edge (2 sync stages plus edge register). The device samples on its rising edge, ≥30 µs later, so no setup issue exists.
- tx_done and tx_err are each high for exactly one cycle. tx_ready returns high on the same cycle as either pulse.
- A tx_valid presented in the same cycle as a tx_done pulse is not accepted until the following cycle.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - command constants CMD_RESET = 8'hFF, CMD_SET_LED = 8'hED, CMD_ENABLE = 8'hF4, RSP_ACK = 8'hFA.
- Sub-module ps2_edge_sync: 2-flop synchronizer plus fe detect for one line. It is instantiated for ps2_clk and ps2_data, and the keyboard receive path can reuse it.

## Test plan
Bench uses INHIBIT_CYC = 20, TIMEOUT_CYC = 2000 and a device model clocking at a 50-cycle period.
- Send 0xED with the device ACKing. Data_oe levels after fe #1–10 (line = ~data_oe) are the line values 1,0,1,1,0,1,1,1, then parity 1, then stop 1. The model receives 0xED, then tx_done pulses once.
- Send 0x01. Parity bit = 0 on the line. Inhibit check: ps2_clk_oe is high for exactly 21 cycles, and ps2_data_oe is high from the 21st.
- The device leaves data high at the ACK edge (NACK). tx_err pulses, no tx_done, and both oe are 0 afterwards.
- The device never clocks. tx_err pulses exactly 2000 cycles after SHIFT entry, and lines are released.
- Pulse clrn low for 1 cycle after fe #4 of a frame. Next cycle both oe = 0 and tx_ready = 1, and a fresh 0xF4 then completes normally.
- Hold tx_valid high with changing tx_data during a frame. Only the byte latched at acceptance is transmitted.
